// File: rtl/usbf_ep_data_port_pkg.sv
// Shared configuration for the endpoint data-register sequencer: default sizes
// and the 3-bit state encoding used by the FSM.
`ifndef USB_EP_NUM
`define USB_EP_NUM 4
`endif
`ifndef USB_EP0_DATA_DATA_W
`define USB_EP0_DATA_DATA_W 8
`endif
`ifndef USB_EP_DATA_TIMEOUT_CYC
`define USB_EP_DATA_TIMEOUT_CYC 255
`endif

package usbf_ep_data_port_pkg;

    localparam int EP_NUM_DEF      = `USB_EP_NUM;
    localparam int DATA_W_DEF      = `USB_EP0_DATA_DATA_W;
    localparam int TIMEOUT_CYC_DEF = `USB_EP_DATA_TIMEOUT_CYC;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WT_WAIT = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WT_WAIT = ST_WT_WAIT,
        RD_WAIT = ST_RD_WAIT,
        RESP    = ST_RESP,
        RECOVER = ST_RECOVER
    } ep_state_e;

endpackage

// File: rtl/usbf_timeout_cnt.sv
// Clear/enable saturating cycle counter; expired_o flags the last allowed
// cycle (count == LIMIT-1) so the owner can leave its state on that edge.
module usbf_timeout_cnt #(
    parameter int LIMIT = 255,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != CNT_W'(LIMIT))) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired_o = (cnt_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/usbf_ep_data_port.sv
// CPU data-register sequencer: one access becomes a one-cycle request pulse,
// then the bus is held until the matching memory-side ready pulse returns.
module usbf_ep_data_port
    import usbf_ep_data_port_pkg::*;
#(
    parameter int EP_NUM      = EP_NUM_DEF,
    parameter int EP_IDX_W    = 2,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       hclk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    input  logic                       req_write_i,
    input  logic [EP_IDX_W-1:0]        req_ep_i,
    input  logic [DATA_W-1:0]          req_wdata_i,
    output logic                       req_ready_o,
    output logic                       rsp_valid_o,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic [EP_NUM-1:0]          ep_data_wt_req_o,
    output logic [EP_NUM-1:0]          ep_data_rd_req_o,
    output logic [DATA_W*EP_NUM-1:0]   ep_tx_data_o,
    input  logic [DATA_W*EP_NUM-1:0]   ep_rx_data_i,
    input  logic                       mem_wt_ready_i,
    input  logic                       mem_rd_ready_i
);

    ep_state_e           state_reg;
    logic [EP_IDX_W-1:0] ep_reg;
    logic                write_reg;
    logic                stale_reg;
    logic                ready_reg;
    logic                rsp_valid_reg;
    logic                rsp_err_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic [EP_NUM-1:0]   wt_req_reg;
    logic [EP_NUM-1:0]   rd_req_reg;

    logic [EP_NUM-1:0]   req_onehot;
    logic [EP_NUM-1:0]   cur_onehot;
    logic [DATA_W-1:0]   tx_slice_reg [EP_NUM];
    logic [DATA_W-1:0]   rx_sel;
    logic                accept;
    logic                req_ep_valid;
    logic                stale_hit;
    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_expired;

    assign accept       = req_valid_i && ready_reg && (state_reg == IDLE);
    assign req_ep_valid = |req_onehot;
    // Only a late pulse of the type that timed out is swallowed in RECOVER.
    assign stale_hit    = write_reg ? mem_wt_ready_i : mem_rd_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < EP_NUM; gi++) begin : g_ep
            assign req_onehot[gi] = (req_ep_i == EP_IDX_W'(gi));
            assign cur_onehot[gi] = (ep_reg == EP_IDX_W'(gi));

            always_ff @(posedge hclk_i or posedge rst_i) begin
                if (rst_i) begin
                    tx_slice_reg[gi] <= '0;
                end else if (accept && req_write_i && req_onehot[gi]) begin
                    tx_slice_reg[gi] <= req_wdata_i;
                end
            end

            assign ep_tx_data_o[gi*DATA_W +: DATA_W] = tx_slice_reg[gi];
        end
    endgenerate

    always_comb begin
        rx_sel = '0;
        for (int i = 0; i < EP_NUM; i++) begin
            if (cur_onehot[i]) begin
                rx_sel = ep_rx_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Counter sits at zero in IDLE/RESP so both WAIT and RECOVER start fresh.
    assign cnt_clr = (state_reg == IDLE) || (state_reg == RESP);
    assign cnt_en  = (state_reg == WT_WAIT) || (state_reg == RD_WAIT) ||
                     (state_reg == RECOVER);

    usbf_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk       (hclk_i),
        .rst       (rst_i),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .expired_o (cnt_expired)
    );

    always_ff @(posedge hclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            ep_reg        <= '0;
            write_reg     <= 1'b0;
            stale_reg     <= 1'b0;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            wt_req_reg    <= '0;
            rd_req_reg    <= '0;
        end else begin
            wt_req_reg    <= '0;
            rd_req_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        ready_reg <= 1'b0;
                        ep_reg    <= req_ep_i;
                        write_reg <= req_write_i;
                        if (!req_ep_valid) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                        end else if (req_write_i) begin
                            state_reg  <= WT_WAIT;
                            wt_req_reg <= req_onehot;
                        end else begin
                            state_reg  <= RD_WAIT;
                            rd_req_reg <= req_onehot;
                        end
                    end
                end
                WT_WAIT: begin
                    if (mem_wt_ready_i || cnt_expired) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= !mem_wt_ready_i;
                        rsp_rdata_reg <= '0;
                        stale_reg     <= !mem_wt_ready_i;
                    end
                end
                RD_WAIT: begin
                    if (mem_rd_ready_i || cnt_expired) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= !mem_rd_ready_i;
                        rsp_rdata_reg <= mem_rd_ready_i ? rx_sel : '0;
                        stale_reg     <= !mem_rd_ready_i;
                    end
                end
                RESP: begin
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= '0;
                    if (stale_reg) begin
                        state_reg <= RECOVER;
                    end else begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (stale_hit || cnt_expired) begin
                        state_reg <= IDLE;
                        stale_reg <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o      = ready_reg;
    assign rsp_valid_o      = rsp_valid_reg;
    assign rsp_err_o        = rsp_err_reg;
    assign rsp_rdata_o      = rsp_rdata_reg;
    assign ep_data_wt_req_o = wt_req_reg;
    assign ep_data_rd_req_o = rd_req_reg;

endmodule

// File: tb/tb_usbf_ep_data_port.sv
// Directed bench for usbf_ep_data_port with a short timeout and a 3-bit
// endpoint index so out-of-range endpoints can be exercised.
module tb_usbf_ep_data_port;

    localparam int EP_NUM      = 4;
    localparam int EP_IDX_W    = 3;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 8;

    logic                     hclk_i;
    logic                     rst_i;
    logic                     req_valid_i;
    logic                     req_write_i;
    logic [EP_IDX_W-1:0]      req_ep_i;
    logic [DATA_W-1:0]        req_wdata_i;
    logic                     req_ready_o;
    logic                     rsp_valid_o;
    logic [DATA_W-1:0]        rsp_rdata_o;
    logic                     rsp_err_o;
    logic [EP_NUM-1:0]        ep_data_wt_req_o;
    logic [EP_NUM-1:0]        ep_data_rd_req_o;
    logic [DATA_W*EP_NUM-1:0] ep_tx_data_o;
    logic [DATA_W*EP_NUM-1:0] ep_rx_data_i;
    logic                     mem_wt_ready_i;
    logic                     mem_rd_ready_i;

    int vectors     = 0;
    int miscompares = 0;
    logic [DATA_W*EP_NUM-1:0] tx_exp;

    usbf_ep_data_port #(
        .EP_NUM      (EP_NUM),
        .EP_IDX_W    (EP_IDX_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .hclk_i           (hclk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_write_i      (req_write_i),
        .req_ep_i         (req_ep_i),
        .req_wdata_i      (req_wdata_i),
        .req_ready_o      (req_ready_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_err_o        (rsp_err_o),
        .ep_data_wt_req_o (ep_data_wt_req_o),
        .ep_data_rd_req_o (ep_data_rd_req_o),
        .ep_tx_data_o     (ep_tx_data_o),
        .ep_rx_data_i     (ep_rx_data_i),
        .mem_wt_ready_i   (mem_wt_ready_i),
        .mem_rd_ready_i   (mem_rd_ready_i)
    );

    initial hclk_i = 1'b0;
    always #5 hclk_i = ~hclk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for req_ready_o, presents one request for one cycle and
    // returns at the negedge of the cycle after acceptance.
    task automatic issue(input logic wr, input logic [EP_IDX_W-1:0] ep,
                         input logic [DATA_W-1:0] wd);
        int n;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 40) begin
            @(negedge hclk_i);
            n++;
        end
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_wait: req_ready_o=%b required 1", req_ready_o);
        end
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_ep_i    = ep;
        req_wdata_i = wd;
        @(negedge hclk_i);
        req_valid_i = 1'b0;
        req_wdata_i = '0;
        $display("issue: wr=%0d ep=%0d wdata=%h", wr, ep, wd);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge hclk_i);
        vectors++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, ep_data_wt_req_o,
             ep_data_rd_req_o, ep_tx_data_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b rsp=%b err=%b rdata=%h wt=%b rd=%b tx=%h required all 0",
                     req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
                     ep_data_wt_req_o, ep_data_rd_req_o, ep_tx_data_o);
        end
        rst_i = 1'b0;
        @(negedge hclk_i);
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: req_ready_o=%b required 1", req_ready_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_write();
        issue(1'b1, 3'd2, 8'hA5);
        tx_exp[23:16] = 8'hA5;
        vectors++;
        if ({req_ready_o, ep_data_wt_req_o, ep_data_rd_req_o, rsp_valid_o} !==
            {1'b0, 4'b0100, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_pulse: ready=%b wt=%b rd=%b rsp=%b required 0/0100/0000/0",
                     req_ready_o, ep_data_wt_req_o, ep_data_rd_req_o, rsp_valid_o);
        end
        vectors++;
        if (ep_tx_data_o !== tx_exp) begin
            miscompares++;
            $display("FAIL wr_txdata: ep_tx_data_o=%h required %h", ep_tx_data_o, tx_exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge hclk_i);
            vectors++;
            if ({req_ready_o, ep_data_wt_req_o, rsp_valid_o} !== 6'b0) begin
                miscompares++;
                $display("FAIL wr_hold: ready=%b wt=%b rsp=%b required 0/0000/0",
                         req_ready_o, ep_data_wt_req_o, rsp_valid_o);
            end
        end
        mem_wt_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_wt_ready_i = 1'b0;
        vectors++;
        if ({rsp_valid_o, rsp_err_o, req_ready_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_rsp: valid=%b err=%b ready=%b required 1/0/0",
                     rsp_valid_o, rsp_err_o, req_ready_o);
        end
        @(negedge hclk_i);
        vectors++;
        if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL wr_done: valid=%b ready=%b required 0/1", rsp_valid_o, req_ready_o);
        end
        $display("test_write done");
    endtask

    task automatic test_read();
        issue(1'b0, 3'd1, 8'h00);
        vectors++;
        if ({ep_data_rd_req_o, ep_data_wt_req_o} !== {4'b0010, 4'b0000}) begin
            miscompares++;
            $display("FAIL rd_pulse: rd=%b wt=%b required 0010/0000",
                     ep_data_rd_req_o, ep_data_wt_req_o);
        end
        @(negedge hclk_i);
        vectors++;
        if (ep_data_rd_req_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL rd_pulse_end: rd=%b required 0000", ep_data_rd_req_o);
        end
        ep_rx_data_i[15:8] = 8'h3C;
        mem_rd_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_rd_ready_i = 1'b0;
        ep_rx_data_i[15:8] = 8'hFF;
        vectors++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 1'b0, 8'h3C}) begin
            miscompares++;
            $display("FAIL rd_rsp: valid=%b err=%b rdata=%h required 1/0/3c",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        $display("test_read done");
    endtask

    task automatic test_timeout_stale();
        ep_rx_data_i[31:24] = 8'h77;
        issue(1'b0, 3'd3, 8'h00);
        for (int k = 2; k <= 8; k++) begin
            @(negedge hclk_i);
            vectors++;
            if ({rsp_valid_o, req_ready_o} !== 2'b00) begin
                miscompares++;
                $display("FAIL to_wait: cycle=%0d valid=%b ready=%b required 0/0",
                         k, rsp_valid_o, req_ready_o);
            end
        end
        @(negedge hclk_i);
        vectors++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL to_rsp: valid=%b err=%b rdata=%h required 1/1/00",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        repeat (2) @(negedge hclk_i);
        vectors++;
        if ({rsp_valid_o, req_ready_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL to_recover: valid=%b ready=%b required 0/0", rsp_valid_o, req_ready_o);
        end
        @(negedge hclk_i);
        mem_rd_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_rd_ready_i = 1'b0;
        vectors++;
        if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL to_stale_exit: valid=%b ready=%b required 0/1", rsp_valid_o, req_ready_o);
        end
        issue(1'b1, 3'd0, 8'h11);
        tx_exp[7:0] = 8'h11;
        mem_rd_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_rd_ready_i = 1'b0;
        repeat (2) begin
            @(negedge hclk_i);
            vectors++;
            if (rsp_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL to_next_early: rsp_valid_o=%b required 0", rsp_valid_o);
            end
        end
        mem_wt_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_wt_ready_i = 1'b0;
        vectors++;
        if ({rsp_valid_o, rsp_err_o} !== 2'b10 || ep_tx_data_o !== tx_exp) begin
            miscompares++;
            $display("FAIL to_next_rsp: valid=%b err=%b tx=%h required 1/0/%h",
                     rsp_valid_o, rsp_err_o, ep_tx_data_o, tx_exp);
        end
        $display("test_timeout_stale done");
    endtask

    task automatic test_recover_timeout();
        issue(1'b1, 3'd1, 8'h22);
        tx_exp[15:8] = 8'h22;
        repeat (8) @(negedge hclk_i);
        vectors++;
        if ({rsp_valid_o, rsp_err_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL rec_rsp: valid=%b err=%b required 1/1", rsp_valid_o, rsp_err_o);
        end
        repeat (3) @(negedge hclk_i);
        mem_rd_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_rd_ready_i = 1'b0;
        repeat (4) @(negedge hclk_i);
        vectors++;
        if (req_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rec_hold: req_ready_o=%b required 0", req_ready_o);
        end
        @(negedge hclk_i);
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rec_exit: req_ready_o=%b required 1", req_ready_o);
        end
        $display("test_recover_timeout done");
    endtask

    task automatic test_expiry_completion();
        issue(1'b1, 3'd3, 8'h5A);
        tx_exp[31:24] = 8'h5A;
        repeat (2) @(negedge hclk_i);
        mem_rd_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_rd_ready_i = 1'b0;
        vectors++;
        if (rsp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL exp_rd_ignored: rsp_valid_o=%b required 0", rsp_valid_o);
        end
        repeat (4) @(negedge hclk_i);
        mem_wt_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_wt_ready_i = 1'b0;
        vectors++;
        if ({rsp_valid_o, rsp_err_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL exp_rsp: valid=%b err=%b required 1/0", rsp_valid_o, rsp_err_o);
        end
        @(negedge hclk_i);
        vectors++;
        if (req_ready_o !== 1'b1 || ep_tx_data_o !== tx_exp) begin
            miscompares++;
            $display("FAIL exp_no_recover: ready=%b tx=%h required 1/%h",
                     req_ready_o, ep_tx_data_o, tx_exp);
        end
        $display("test_expiry_completion done");
    endtask

    task automatic test_invalid_ep();
        issue(1'b1, 3'd5, 8'hEE);
        vectors++;
        if ({ep_data_wt_req_o, ep_data_rd_req_o} !== 8'h00) begin
            miscompares++;
            $display("FAIL inv_pulse: wt=%b rd=%b required 0000/0000",
                     ep_data_wt_req_o, ep_data_rd_req_o);
        end
        vectors++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 1'b1, 8'h00} ||
            ep_tx_data_o !== tx_exp) begin
            miscompares++;
            $display("FAIL inv_rsp: valid=%b err=%b rdata=%h tx=%h required 1/1/00/%h",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o, ep_tx_data_o, tx_exp);
        end
        @(negedge hclk_i);
        vectors++;
        if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL inv_done: valid=%b ready=%b required 0/1", rsp_valid_o, req_ready_o);
        end
        $display("test_invalid_ep done");
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'd0, 8'h00);
        @(negedge hclk_i);
        rst_i = 1'b1;
        #1;
        tx_exp = '0;
        vectors++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, ep_data_wt_req_o,
             ep_data_rd_req_o, ep_tx_data_o} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: ready=%b rsp=%b wt=%b rd=%b tx=%h required all 0",
                     req_ready_o, rsp_valid_o, ep_data_wt_req_o, ep_data_rd_req_o, ep_tx_data_o);
        end
        @(negedge hclk_i);
        rst_i = 1'b0;
        mem_rd_ready_i = 1'b1;
        @(negedge hclk_i);
        mem_rd_ready_i = 1'b0;
        vectors++;
        if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_ready: ready=%b valid=%b required 1/0", req_ready_o, rsp_valid_o);
        end
        repeat (3) begin
            @(negedge hclk_i);
            vectors++;
            if (rsp_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_no_rsp: rsp_valid_o=%b required 0", rsp_valid_o);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst_i          = 1'b1;
        req_valid_i    = 1'b0;
        req_write_i    = 1'b0;
        req_ep_i       = '0;
        req_wdata_i    = '0;
        ep_rx_data_i   = '0;
        mem_wt_ready_i = 1'b0;
        mem_rd_ready_i = 1'b0;
        tx_exp         = '0;

        test_reset();
        test_write();
        test_read();
        test_timeout_stale();
        test_recover_timeout();
        test_expiry_completion();
        test_invalid_ep();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
